// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
// Shared definitions for the Montgomery multiplier and the RSA exponentiation
// controller that sits above it.
//   DEFAULT_WIDTH : default operand/modulus width in bits
//   mont_state_e  : FSM state encoding (IDLE, LOOP, REDUCE, FIN)
// -----------------------------------------------------------------------------
package mont_pkg;

    localparam int DEFAULT_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOP   = 2'd1,
        REDUCE = 2'd2,
        FIN    = 2'd3
    } mont_state_e;

endpackage

// File: rtl/mont_step.sv
// -----------------------------------------------------------------------------
// mont_step
// One fused add/shift step of radix-2 Montgomery multiplication.
//   t      in  WIDTH+1  running partial result (t < 2m)
//   b      in  WIDTH    multiplier operand
//   m      in  WIDTH    odd modulus
//   a_bit  in  1        current multiplicand bit
//   t_next out WIDTH+1  (t + a_bit*b + q*m) >> 1
// -----------------------------------------------------------------------------
module mont_step
    import mont_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic             a_bit,
    output logic [WIDTH:0]   t_next
);

    logic             q;
    logic [WIDTH-1:0] addB;
    logic [WIDTH-1:0] addM;
    logic [WIDTH+1:0] sum;

    // q makes the sum even so the shift is an exact division by two
    // (m is odd, so adding m flips the low bit).
    assign q    = t[0] ^ (a_bit & b[0]);
    assign addB = a_bit ? b : '0;
    assign addM = q ? m : '0;

    // t < 2m and b, m < 2^WIDTH keep the sum below 2^(WIDTH+2).
    assign sum    = {1'b0, t} + {2'b00, addB} + {2'b00, addM};
    assign t_next = sum[WIDTH+1:1];

endmodule

// File: rtl/montgomery_param.sv
// -----------------------------------------------------------------------------
// montgomery_param
// Radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, one multiplier
// bit per clock followed by a single conditional subtraction.
//   clk     in   1      clock, rising edge
//   resetn  in   1      asynchronous active-low reset
//   start   in   1      request, sampled only in IDLE
//   abort   in   1      cancel the operation in progress
//   in_a    in   WIDTH  multiplicand (a < m)
//   in_b    in   WIDTH  multiplier (b < m)
//   in_m    in   WIDTH  modulus (odd)
//   result  out  WIDTH  registered product, held until the next accepted start
//   done    out  1      one-cycle pulse, result/err valid
//   busy    out  1      operation in progress
//   err     out  1      even modulus flagged with done
// -----------------------------------------------------------------------------
module montgomery_param
    import mont_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mont_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   tStep;
    logic [WIDTH-1:0] tMinusM;
    logic             tGeM;
    logic             lastIter;

    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .t      (t_q),
        .b      (b_q),
        .m      (m_q),
        .a_bit  (a_q[0]),
        .t_next (tStep)
    );

    // Since t < 2m, t - m fits in WIDTH bits whenever t >= m, so the carry
    // bit of t can be dropped from the subtraction.
    assign tGeM     = (t_q >= {1'b0, m_q});
    assign tMinusM  = t_q[WIDTH-1:0] - m_q;
    assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state logic. The multiplicand is shifted right each iteration so
    // the current bit is always a_q[0]; the counter only tracks termination.
    // done/busy are registered so done lands one cycle after FIN and busy
    // drops as FIN is entered.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    m_d   = in_m;
                    t_d   = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (!in_m[0]) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = FIN;
                    end else begin
                        state_d  = LOOP;
                    end
                end
            end
            LOOP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    t_d   = tStep;
                    a_d   = a_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (lastIter) begin
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    result_d = tGeM ? tMinusM : t_q[WIDTH-1:0];
                    state_d  = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = !abort;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOOP) || (state_d == REDUCE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_montgomery_param.sv
// -----------------------------------------------------------------------------
// tb_montgomery_param
// Self-checking bench for montgomery_param at WIDTH=8. Expected results are
// pushed to a scoreboard when a start is issued and popped when done pulses.
// -----------------------------------------------------------------------------
module tb_montgomery_param;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             err;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             err;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               unexpectedDone = 0;
    int               doneCount = 0;
    logic [WIDTH-1:0] lastRes = '0;
    exp_t             sb[$];

    montgomery_param #(
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .abort  (abort),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure done latency from the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: reduce a*b mod m, then halve modulo m WIDTH times.
    function automatic logic [WIDTH-1:0] montRef(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] m);
        longint unsigned x;
        x = (longint'(a) * longint'(b)) % longint'(m);
        for (int i = 0; i < WIDTH; i++) begin
            x = x[0] ? (x + longint'(m)) >> 1 : x >> 1;
        end
        return WIDTH'(x);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge (or with start about to be sampled); drives one
    // start, optionally with abort, and scrambles the inputs after acceptance.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] m, input bit expectIt,
                                 input bit withAbort);
        exp_t e;
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        abort = withAbort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        in_a  = WIDTH'($urandom);
        in_b  = WIDTH'($urandom);
        in_m  = WIDTH'($urandom);
        if (expectIt) begin
            e.res = m[0] ? montRef(a, b, m) : '0;
            e.err = ~m[0];
            e.cyc = cyc + (m[0] ? WIDTH + 2 : 1);
            lastRes = e.res;
            sb.push_back(e);
        end
    endtask

    task automatic waitDone(output int busyCnt);
        bit gotDone;
        gotDone = 1'b0;
        busyCnt = 0;
        for (int n = 0; n < 100 && !gotDone; n++) begin
            @(negedge clk);
            if (done) gotDone = 1'b1;
            else if (busy) busyCnt++;
        end
        checkOutput("done_seen", 32'(gotDone), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (resetn && done) begin
            exp_t e;
            doneCount++;
            if (sb.size() == 0) begin
                unexpectedDone++;
            end else begin
                e = sb.pop_front();
                checkOutput("result", 32'(result), 32'(e.res));
                checkOutput("err", 32'(err), 32'(e.err));
                checkOutput("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc;
        int doneBefore;
        logic [WIDTH-1:0] ra, rb, rm;

        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_m   = '0;
        #23;
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] basic products");
        applyStimulus(8'd5, 8'd7, 8'h0D, 1, 0);
        waitDone(bc);
        checkOutput("spec_5x7", 32'(result), 32'h01);
        applyStimulus(8'd1, 8'h03, 8'h0D, 1, 0);
        waitDone(bc);
        checkOutput("r_mod_m", 32'(result), 32'h09);
        applyStimulus(8'd0, 8'h03, 8'h0D, 1, 0);
        waitDone(bc);

        $display("[TB] final subtract path and busy length");
        applyStimulus(8'hFE, 8'hFE, 8'hFF, 1, 0);
        waitDone(bc);
        checkOutput("busy_cycles", 32'(bc), 32'(WIDTH + 1));
        checkOutput("fe_fe_ff", 32'(result), 32'h01);

        $display("[TB] even modulus");
        applyStimulus(8'd5, 8'd7, 8'h0C, 1, 0);
        waitDone(bc);
        @(negedge clk);
        checkOutput("err_held", 32'(err), 32'd1);
        applyStimulus(8'd3, 8'd4, 8'h0D, 1, 0);
        waitDone(bc);

        $display("[TB] start while busy ignored");
        applyStimulus(8'd7, 8'd9, 8'h0D, 1, 0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        in_a  = 8'd1;
        in_b  = 8'd1;
        in_m  = 8'h0C;
        @(negedge clk);
        start = 1'b0;
        waitDone(bc);

        $display("[TB] abort in IDLE");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);
        checkOutput("idle_abort_result", 32'(result), 32'(lastRes));
        abort = 1'b0;

        $display("[TB] abort at LOOP iteration 3");
        doneBefore = doneCount;
        applyStimulus(8'd9, 8'd10, 8'h0B, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", 32'(result), 32'(lastRes));
        repeat (15) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);

        $display("[TB] start and abort together in IDLE");
        applyStimulus(8'd11, 8'd6, 8'h0D, 1, 1);
        waitDone(bc);

        $display("[TB] random back-to-back");
        for (int i = 0; i < 30; i++) begin
            rm = WIDTH'($urandom_range(3, 255)) | 8'd1;
            ra = WIDTH'($urandom_range(0, int'(rm) - 1));
            rb = WIDTH'($urandom_range(0, int'(rm) - 1));
            applyStimulus(ra, rb, rm, 1, 0);
            waitDone(bc);
        end

        $display("[TB] reset mid-LOOP");
        applyStimulus(8'hC3, 8'h5A, 8'hE7, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_result", 32'(result), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_err", 32'(err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (15) @(negedge clk);

        checkOutput("unexpected_done", 32'(unexpectedDone), 32'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
